div6_bcd_counter: RTL and testbench
===================================

# div6_bcd_counter

Downstream consumer of the divide-by-6 stage: samples the `div6` waveform, converts each rising edge into a single-cycle tick, and counts ticks in a two-digit BCD counter with start/stop/clear control. Used as the display-facing count stage of the divider chain. Its `carry` output drives the next counter stage.

## Interface
- `TENS_MAX`, default 5: maximum tens digit, legal 1..9. The count modulus is 10*(TENS_MAX+1); the default modulus is 60.

- `clk` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset; the port is named `reset`.
- `div6` in 1: divided waveform from the divide-by-6 stage. Synchronous to `clk`, 3 cycles high then 3 cycles low.
- `start` in 1: level, sampled each cycle; request to run.
- `stop` in 1: level, sampled each cycle; request to hold.
- `clear` in 1: level, sampled each cycle; synchronous clear to the idle state.
- `ones` out 4: BCD ones digit, 0..9.
- `tens` out 4: BCD tens digit, 0..TENS_MAX.
- `carry` out 1: one-cycle pulse on wrap from the maximum count to 00.
- `running` out 1: high while in RUN.

## Operation
- **Edge detect:** register `div6_q` (reset 0). `tick = div6 & ~div6_q` is combinational. It produces exactly one tick per `div6` period, every 6 clk cycles.
- **FSM states:** IDLE (reset state), RUN, HOLD.
- **FSM priority per cycle:** `clear` > `stop` > `start`.
  - `clear` from any state → IDLE; `ones`/`tens` ← 0.
  - `stop` in RUN → HOLD; ignored in IDLE or HOLD.
  - `start` in IDLE or HOLD → RUN; ignored in RUN.
- **Increment condition:** state == RUN && `tick` && !`stop` && !`clear`.
  - A tick in the same cycle as `start` (from IDLE or HOLD) is not counted.
  - A tick in the same cycle as `stop` is not counted.
- **Digit arithmetic:**
  - `ones` < 9: `ones`+1.
  - `ones` == 9: `ones` ← 0 and `tens`+1.
  - `ones` == 9 and `tens` == TENS_MAX: both ← 0, and `carry` ← 1 for exactly that one cycle.
- **No illegal codes:** digits never take a non-BCD value. Any out-of-range value is forced to 0 on the next increment. This state is unreachable in normal operation.
- **HOLD** retains the digits. RUN re-entered from HOLD resumes from the held value. RUN entered from IDLE starts from 00.
- **Reset mid-count:** immediately forces IDLE, digits 00, `carry` 0, `running` 0, `div6_q` 0. No tick is counted until after `start`.

## Timing
- **Reset values:** `ones`=0, `tens`=0, `carry`=0, `running`=0; FSM is IDLE.
- **Tick latency:** the digits change at the first clk edge at which `div6` is sampled 1 after having been sampled 0. The new value is visible one cycle after `div6` rises.
- **`carry`:** registered. It is high in the same cycle that the digits first read 00 after wrap, and low the next cycle.
- **`running`:** registered FSM decode. It goes high the cycle after `start` is sampled and low the cycle after `stop` or `clear` is sampled.
- **Count rate:** the digits advance once per 6 clk cycles while RUN is held. The default counter wraps every 360 clk cycles.

## Structure
- **Shared package `div_pkg`:**
  - state enum `cnt_state_t` {IDLE, RUN, HOLD}
  - constant `BCD_MAX` = 4'd9
  - constant `DIV6_PERIOD` = 6, for benches
- **Sub-module `bcd_digit`:** one BCD digit with inputs `inc` and `clr`, a parameterised max value, outputs the digit value and a wrap flag. It is instantiated twice, with the ones wrap flag chaining into the tens `inc`.
- **Top level:** the edge detect, FSM and `carry` register live in the top module.

## Test plan
- **Reset:** pull `reset` low mid-RUN at count 37 → all outputs 0 asynchronously. After release with `div6` toggling and no `start` → digits stay 00.
- **Basic count:** `start` one cycle, then 10 `div6` periods → `ones`=0, `tens`=1; each increment lands one cycle after a `div6` rise.
- **Wrap:** run 60 periods from 00 → digits read 59 then 00. `carry` is high exactly one cycle, coincident with 00.
- **Hold/resume:** stop at 23, hold for 5 periods → stays 23. `start` again, 2 periods → 25.
- **Priority:** assert `clear`, `stop` and `start` together during a tick at count 12 → IDLE, 00, `running`=0. Assert `stop` coincident with a tick at 12 → holds 12.
- **Parameter:** `TENS_MAX`=2 → wraps 29 → 00 with `carry` after 30 periods.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider-chain count stage.
// Also holds the single-digit BCD increment helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } cnt_state_t;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam int         DIV6_PERIOD = 6;

  // Values at or beyond max_v (including illegal codes) roll to 0.
  function automatic logic [3:0] bcd_next(input logic [3:0] v, input logic [3:0] max_v);
    logic [3:0] r;
    if (v < max_v) begin
      r = v + 4'd1;
    end else begin
      r = 4'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/div6_bcd_counter_bcd_digit.sv
// One BCD digit with synchronous clear and increment.
// The wrap flag lets a higher digit chain off this one in the same cycle.
module bcd_digit
  import div_pkg::*;
#(
  parameter logic [3:0] MAX_VAL = BCD_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] value,
  output logic       wrap
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = 4'd0;
    end else if (inc) begin
      value_d = bcd_next(value_q, MAX_VAL);
    end else begin
      value_d = value_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  // An out-of-range code rolls to 0 without signalling a wrap.
  assign wrap  = inc & ~clr & (value_q == MAX_VAL);
  assign value = value_q;

endmodule

// File: rtl/div6_bcd_counter.sv
// Count stage fed by the divide-by-6 waveform: rising-edge tick detect,
// IDLE/RUN/HOLD control and a two-digit BCD counter with carry out.
module div6_bcd_counter
  import div_pkg::*;
#(
  parameter int unsigned TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       div6,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry,
  output logic       running
);

  localparam logic [3:0] TENS_MAX_L = 4'(TENS_MAX);

  cnt_state_t state_q;
  cnt_state_t state_d;
  logic       div6_q;
  logic       carry_q;
  logic       carry_d;
  logic       running_q;
  logic       running_d;
  logic       tick_s;
  logic       inc_s;
  logic       ones_wrap_s;
  logic       tens_wrap_s;

  assign tick_s = div6 & ~div6_q;
  // Ticks coinciding with stop/clear are dropped; start only arrives outside RUN.
  assign inc_s  = (state_q == RUN) & tick_s & ~stop & ~clear;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = HOLD;
      end else begin
        state_d = state_q;
      end
    end else if (start) begin
      case (state_q)
        IDLE:    state_d = RUN;
        HOLD:    state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = RUN;
        HOLD:    state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    running_d = (state_d == RUN);
    carry_d   = tens_wrap_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      div6_q    <= 1'b0;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div6_q    <= div6;
      carry_q   <= carry_d;
      running_q <= running_d;
    end
  end

  bcd_digit #(
    .MAX_VAL(BCD_MAX)
  ) u_ones (
    .clk  (clk),
    .reset(reset),
    .inc  (inc_s),
    .clr  (clear),
    .value(ones),
    .wrap (ones_wrap_s)
  );

  bcd_digit #(
    .MAX_VAL(TENS_MAX_L)
  ) u_tens (
    .clk  (clk),
    .reset(reset),
    .inc  (ones_wrap_s),
    .clr  (clear),
    .value(tens),
    .wrap (tens_wrap_s)
  );

  assign carry   = carry_q;
  assign running = running_q;

endmodule

// File: tb/tb_div6_bcd_counter.sv
// Bench for div6_bcd_counter: default (mod 60) and TENS_MAX=2 (mod 30) instances
// share stimulus and are compared every cycle against an integer-count model.
module tb_div6_bcd_counter;
  import div_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       div6 = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] ones_a, tens_a, ones_b, tens_b;
  logic       carry_a, running_a, carry_b, running_b;

  int tests = 0;
  int fails = 0;
  int cnt[2];
  int modv[2];
  bit carry_m[2];
  bit run_m;
  bit prev_m;
  int phase;

  div6_bcd_counter dut_a (
    .clk(clk), .reset(reset), .div6(div6), .start(start), .stop(stop), .clear(clear),
    .ones(ones_a), .tens(tens_a), .carry(carry_a), .running(running_a)
  );

  div6_bcd_counter #(.TENS_MAX(2)) dut_b (
    .clk(clk), .reset(reset), .div6(div6), .start(start), .stop(stop), .clear(clear),
    .ones(ones_b), .tens(tens_b), .carry(carry_b), .running(running_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [3:0] o, input logic [3:0] t,
                     input logic c, input logic r);
    logic [3:0] eo, et;
    eo = 4'(cnt[k] % 10);
    et = 4'(cnt[k] / 10);
    tests++;
    assert (o === eo) else begin
      fails++;
      $error("FAIL %s ones[%0d]: got %0d want %0d", tag, k, o, eo);
    end
    tests++;
    assert (t === et) else begin
      fails++;
      $error("FAIL %s tens[%0d]: got %0d want %0d", tag, k, t, et);
    end
    tests++;
    assert (c === carry_m[k]) else begin
      fails++;
      $error("FAIL %s carry[%0d]: got %b want %b", tag, k, c, carry_m[k]);
    end
    tests++;
    assert (r === run_m) else begin
      fails++;
      $error("FAIL %s running[%0d]: got %b want %b", tag, k, r, run_m);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, 0, ones_a, tens_a, carry_a, running_a);
    chk(tag, 1, ones_b, tens_b, carry_b, running_b);
  endtask

  // Drive one cycle of inputs at the falling edge, update the model at the rising edge.
  task automatic step(input bit s, input bit p, input bit c, input string tag);
    bit tick, inc;
    div6  = (phase < 3);
    start = s;
    stop  = p;
    clear = c;
    @(posedge clk);
    tick   = div6 && !prev_m;
    prev_m = div6;
    inc    = run_m && tick && !p && !c;
    if (c) run_m = 1'b0;
    else if (p) run_m = 1'b0;
    else if (s) run_m = 1'b1;
    for (int k = 0; k < 2; k++) begin
      carry_m[k] = 1'b0;
      if (c) begin
        cnt[k] = 0;
      end else if (inc) begin
        cnt[k] = (cnt[k] + 1) % modv[k];
        carry_m[k] = (cnt[k] == 0);
      end
    end
    phase = (phase + 1) % DIV6_PERIOD;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, tag);
  endtask

  // Step until the mod-60 count equals target; optionally also until the next cycle carries a tick.
  task automatic run_until(input int target, input bit want_tick, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (cnt[0] == target && (!want_tick || phase == 0)) found = 1'b1;
      else step(1'b0, 1'b0, 1'b0, tag);
    end
    tests++;
    assert (found) else begin
      fails++;
      $error("FAIL %s timeout: got count %0d want %0d", tag, cnt[0], target);
    end
  endtask

  initial begin
    modv[0] = 60;
    modv[1] = 30;
    cnt[0] = 0;
    cnt[1] = 0;
    carry_m[0] = 1'b0;
    carry_m[1] = 1'b0;
    run_m  = 1'b0;
    prev_m = 1'b0;
    phase  = 0;

    #2;
    check_all("reset_values");
    @(negedge clk);
    reset = 1'b1;
    idle_steps(12, "idle_no_start");

    // Tick coincides with start and must not count; then 10 periods.
    step(1'b1, 1'b0, 1'b0, "start");
    idle_steps(60, "basic_count");
    idle_steps(300, "wrap");

    step(1'b0, 1'b0, 1'b1, "clear_pre_hold");
    step(1'b1, 1'b0, 1'b0, "start_hold");
    run_until(23, 1'b0, "to_23");
    step(1'b0, 1'b1, 1'b0, "stop_23");
    idle_steps(30, "hold_23");
    step(1'b1, 1'b0, 1'b0, "resume");
    idle_steps(12, "resume_25");

    step(1'b0, 1'b0, 1'b1, "clear_pre_prio");
    step(1'b1, 1'b0, 1'b0, "start_prio");
    run_until(12, 1'b1, "to_12a");
    step(1'b1, 1'b1, 1'b1, "all_three");
    idle_steps(8, "after_all_three");
    step(1'b1, 1'b0, 1'b0, "start_prio2");
    run_until(12, 1'b1, "to_12b");
    step(1'b0, 1'b1, 1'b0, "stop_on_tick");
    idle_steps(12, "held_12");

    step(1'b0, 1'b0, 1'b1, "clear_pre_reset");
    step(1'b1, 1'b0, 1'b0, "start_reset");
    run_until(37, 1'b0, "to_37");
    #2;
    reset = 1'b0;
    #1;
    cnt[0] = 0;
    cnt[1] = 0;
    carry_m[0] = 1'b0;
    carry_m[1] = 1'b0;
    run_m  = 1'b0;
    prev_m = 1'b0;
    check_all("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_steps(30, "post_reset_no_start");

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 120) == 0), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
